// File: rtl/pmem_arbiter_pkg.sv
// Shared types and widths for the two-client physical-memory arbiter.
package arbiter_types;

  localparam int ADDR_W = 32;   // byte address width
  localparam int LINE_W = 256;  // cacheline width in bits

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory signals around the arbiter.
// slave: the arbiter's view; master: the caches and memory driving it.
interface pmem_arbiter_if;
  import arbiter_types::*;

  // icache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  // dcache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  // physical-memory side
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter serialising icache line reads and dcache line
// reads/write-backs onto a single cacheline-wide memory port. Memory-side
// outputs are registered; client responses are combinational pass-throughs.
module pmem_arbiter
  import arbiter_types::*;
(
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  arb_client_t       last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic              i_resp, d_resp;

  logic i_req, d_req, grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;
  // dcache wins when alone, or on a tie when icache held the last grant.
  assign grant_d = d_req && (!i_req || last_grant_q == CLIENT_I);

  // Next state, values to latch into the memory-side registers, client responses.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_resp         = 1'b0;
    d_resp         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          // Read and write together is treated as a write-back.
          state_d        = SERVE_D;
          last_grant_d   = CLIENT_D;
          pmem_read_d    = bus.d_read & ~bus.d_write;
          pmem_write_d   = bus.d_write;
          pmem_address_d = bus.d_address;
          pmem_wdata_d   = bus.d_wdata;
        end else if (i_req) begin
          state_d        = SERVE_I;
          last_grant_d   = CLIENT_I;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = bus.i_address;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          i_resp       = 1'b1;
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          d_resp       = 1'b1;
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant history and memory-side registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= CLIENT_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.i_resp       = i_resp;
  assign bus.d_resp       = d_resp;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule
